ifu_icache_burst: RTL and testbench
===================================

Name: ifu_icache_burst

Overview:
Parametrised instruction-cache model for the IFU fetch path and the next generation of the fixed 4-wide I-cache model. It accepts a fetch request (PC plus instruction count) on a valid/ready handshake. After a configurable latency it returns the instructions as one or more LANES-wide beats on a valid/ready response channel, with full backpressure, a lane mask and a last-beat flag. The backing store is an internal ROM; the block sits between the DPFU fetch control and the decode buffer.

Parameters:
INSTR_W, 32, instruction width in bits
LANES, 4, instructions per response beat (power of 2, ≥1)
DEPTH, 128, ROM entries (power of 2); AW = $clog2(DEPTH)
LATENCY, 3, cycles from request acceptance to first beat valid (≥1)
CNT_W, 4, width of req_count; max request is 2**CNT_W-1 instructions

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  fetch request valid
req_ready  out  1  block can accept a request
req_addr  in  32  byte PC of first instruction
req_count  in  CNT_W  number of instructions; 0 means LANES
rsp_valid  out  1  response beat valid
rsp_ready  in  1  consumer accepts beat
rsp_data  out  LANES*INSTR_W  lane i at bits [i*INSTR_W +: INSTR_W], lane 0 = lowest PC
rsp_mask  out  LANES  bit i = lane i holds a valid instruction
rsp_last  out  1  final beat of the request
busy  out  1  request in flight (not IDLE)

Behaviour:
- Reset (async assert, sync deassert): state IDLE; req_ready=1, rsp_valid=0, rsp_data=0, rsp_mask=0, rsp_last=0, busy=0, latency counter 0. Reset mid-burst aborts the burst with no further beats.
- States: IDLE, LAT, BEAT.
- IDLE: req_ready=1. On req_valid&&req_ready at edge E0, the block latches base=req_addr[AW+1:2] and remaining=(req_count==0 ? LANES : req_count), then moves to LAT. req_addr[1:0] is ignored unless the optional feature is enabled.
- LAT: counts LATENCY-1 further edges, then enters BEAT. The first rsp_valid=1 is visible after edge E0+LATENCY.
- BEAT: beat size n=min(remaining,LANES). Lane i<n = ROM[(base+i) mod DEPTH]; lanes ≥n drive 0 with mask bit 0. rsp_last=1 when remaining≤LANES.
- While rsp_valid && !rsp_ready, rsp_data, rsp_mask and rsp_last hold stable.
- On rsp_valid&&rsp_ready, base advances by n mod DEPTH and remaining decreases by n. If last, the block goes to IDLE (req_ready=1 next cycle). Otherwise the next beat is valid the next cycle with no bubble and no additional latency.
- req_ready=0 and busy=1 in LAT and BEAT; requests presented then are not accepted.
- Address wrap: indices wrap modulo DEPTH inside a beat and across beats.
- ROM contents at init: ROM[k] = k<<2, truncated to INSTR_W (each word equals its byte address).

Optional Feature:
ICACHE_MISALIGN_ERR_EN.
- Defined: adds output rsp_err (1). A request with req_addr[1:0]!=0 skips LAT and returns a single beat the next cycle with rsp_err=1, rsp_mask=0, rsp_data=0, rsp_last=1. Aligned requests drive rsp_err=0. rsp_err resets to 0.
- Undefined: no rsp_err port; low address bits are ignored.

Decomposition:
- Package ifu_icache_pkg: state enum icache_state_t {IDLE,LAT,BEAT}, default parameter constants, and a function computing beat size min(remaining,LANES).
- Sub-module ifu_icache_rom: DEPTH×INSTR_W ROM with LANES combinational read ports at consecutive wrapped indices from a base; it owns the initialisation.

Test Plan:
- Reset: hold reset_n=0 mid-clock -> outputs zero immediately, req_ready=1; release -> idle.
- addr 0x10, count 4, rsp_ready=1 -> after LATENCY=3 edges a single beat: data {0x1C,0x18,0x14,0x10}, mask 4'b1111, last=1; req_ready=1 the following cycle.
- addr 0x0, count 6 -> beat 1 {0xC,0x8,0x4,0x0} mask 1111 last=0; next cycle beat 2 {0,0,0x14,0x10} mask 0011 last=1.
- addr 0x1F8, count 4 -> data {0x004,0x000,0x1FC,0x1F8} (wrap); count 0 also yields 4 lanes.
- Backpressure: count 8, rsp_ready=0 for 5 cycles on beat 1 -> beat 1 stable; release -> beats delivered back-to-back; req_valid pulsed during busy is ignored.
- Reset_n pulsed during beat 1 of an 8-instruction request -> rsp_valid=0 at once, no beat 2; with ICACHE_MISALIGN_ERR_EN, addr 0x12 -> one beat with rsp_err=1, mask 0, last=1.

Source files
------------

// File: rtl/ifu_icache_burst_pkg.sv
// Shared types, default parameters and helpers for the IFU burst I-cache.
package ifu_icache_pkg;

    localparam int INSTR_W_DEF = 32;
    localparam int LANES_DEF   = 4;
    localparam int DEPTH_DEF   = 128;
    localparam int LATENCY_DEF = 3;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        IDLE,
        LAT,
        BEAT
    } icache_state_t;

    // Instructions carried by the current beat: min(remaining, lanes).
    function automatic int beat_size(input int remaining, input int lanes);
        return (remaining < lanes) ? remaining : lanes;
    endfunction

endpackage

// File: rtl/ifu_icache_burst_if.sv
// Fetch request / burst response channel between DPFU fetch control (master)
// and the I-cache (slave). rsp_err exists only when ICACHE_MISALIGN_ERR_EN
// is defined.
interface ifu_icache_burst_if
    import ifu_icache_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int CNT_W   = CNT_W_DEF
) ();

    logic                       req_valid;
    logic                       req_ready;
    logic [31:0]                req_addr;
    logic [CNT_W-1:0]           req_count;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [LANES*INSTR_W-1:0]   rsp_data;
    logic [LANES-1:0]           rsp_mask;
    logic                       rsp_last;
    logic                       busy;
`ifdef ICACHE_MISALIGN_ERR_EN
    logic                       rsp_err;
`endif

    modport master (
        output req_valid, req_addr, req_count, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_mask, rsp_last, busy
`ifdef ICACHE_MISALIGN_ERR_EN
        , input rsp_err
`endif
    );

    modport slave (
        input  req_valid, req_addr, req_count, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_mask, rsp_last, busy
`ifdef ICACHE_MISALIGN_ERR_EN
        , output rsp_err
`endif
    );

endinterface

// File: rtl/ifu_icache_burst_rom.sv
// Constant instruction ROM with LANES combinational read ports at consecutive
// indices from base_i, wrapping modulo DEPTH. Word k holds its byte address.
module ifu_icache_rom #(
    parameter int INSTR_W = 32,
    parameter int LANES   = 4,
    parameter int DEPTH   = 128,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic [AW-1:0]              base_i,
    output logic [LANES*INSTR_W-1:0]   data_o
);

    // NOTE: the ROM is a constant table, not state, so it has no reset and
    // no clock; synthesis folds it into logic.
    logic [INSTR_W-1:0] mem [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_init
        assign mem[k] = INSTR_W'(32'(k) << 2);
    end

    // Read LANES consecutive words; the AW-bit add wraps at DEPTH for free.
    always_comb begin
        data_o = '0;
        for (int i = 0; i < LANES; i++) begin
            data_o[i*INSTR_W +: INSTR_W] = mem[base_i + AW'(i)];
        end
    end

endmodule

// File: rtl/ifu_icache_burst.sv
// IFU I-cache burst model: accepts a fetch request, waits LATENCY cycles,
// then streams LANES-wide beats with backpressure, lane mask and last flag.
// Optional feature macro: ICACHE_MISALIGN_ERR_EN (misaligned PC returns a
// single error beat without latency).
module ifu_icache_burst
    import ifu_icache_pkg::*;
#(
    parameter int INSTR_W = INSTR_W_DEF,
    parameter int LANES   = LANES_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int LATENCY = LATENCY_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    ifu_icache_burst_if.slave bus
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(LANES + 1);
    localparam int REM_W = (CNT_W > LW) ? CNT_W : LW;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    icache_state_t             state_q, state_d;
    logic [AW-1:0]             base_q, base_d;
    logic [REM_W-1:0]          rem_q, rem_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic [LANES*INSTR_W-1:0]  rom_data;
    logic                      err_w;
    logic                      last_w;
    int                        beat_n;

    // Upper PC bits (and the low bits when misalign checking is off) are not
    // part of the ROM index.
    logic unused_addr;
    assign unused_addr = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

    ifu_icache_rom #(
        .INSTR_W (INSTR_W),
        .LANES   (LANES),
        .DEPTH   (DEPTH),
        .AW      (AW)
    ) u_rom (
        .base_i  (base_q),
        .data_o  (rom_data)
    );

    assign beat_n = beat_size(int'(rem_q), LANES);
    assign last_w = err_w || (rem_q <= REM_W'(LANES));

`ifdef ICACHE_MISALIGN_ERR_EN
    logic err_q, err_d;
    assign err_w       = err_q;
    assign bus.rsp_err = (state_q == BEAT) && err_q;

    // Error flag for the single beat returned on a misaligned request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign err_w = 1'b0;
`endif

    // State and burst bookkeeping registers.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            rem_q   <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            rem_q   <= rem_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state: accept in IDLE, count latency in LAT, advance on handshake in BEAT.
    always_comb begin
        // NOTE: every target gets a default first so no path infers a latch.
        state_d = state_q;
        base_d  = base_q;
        rem_d   = rem_q;
        lat_d   = lat_q;
`ifdef ICACHE_MISALIGN_ERR_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    base_d  = bus.req_addr[AW+1:2];
                    rem_d   = (bus.req_count == '0) ? REM_W'(LANES) : REM_W'(bus.req_count);
                    lat_d   = '0;
                    state_d = LAT;
`ifdef ICACHE_MISALIGN_ERR_EN
                    err_d   = (bus.req_addr[1:0] != 2'b00);
                    if (bus.req_addr[1:0] != 2'b00) begin
                        state_d = BEAT;
                    end
`endif
                end
            end
            LAT: begin
                if (lat_q == LAT_W'(LATENCY - 1)) begin
                    state_d = BEAT;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            BEAT: begin
                if (bus.rsp_ready) begin
                    base_d = base_q + AW'(beat_n);
                    rem_d  = rem_q - REM_W'(beat_n);
                    if (last_w) begin
                        state_d = IDLE;
`ifdef ICACHE_MISALIGN_ERR_EN
                        err_d   = 1'b0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from state; inactive lanes and idle cycles drive zero.
    always_comb begin
        bus.req_ready = (state_q == IDLE);
        bus.busy      = (state_q != IDLE);
        bus.rsp_valid = (state_q == BEAT);
        bus.rsp_last  = (state_q == BEAT) && last_w;
        bus.rsp_mask  = '0;
        bus.rsp_data  = '0;
        if ((state_q == BEAT) && !err_w) begin
            for (int i = 0; i < LANES; i++) begin
                if (i < beat_n) begin
                    bus.rsp_mask[i]                   = 1'b1;
                    bus.rsp_data[i*INSTR_W +: INSTR_W] = rom_data[i*INSTR_W +: INSTR_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_ifu_icache_burst.sv
// Self-checking bench for ifu_icache_burst: table of directed requests plus
// hand-written reset, backpressure, max-length and (optional) misalign cases.
`timescale 1ns/1ps
module tb_ifu_icache_burst;
    import ifu_icache_pkg::*;

    localparam int INSTR_W = 32;
    localparam int LANES   = 4;
    localparam int DEPTH   = 128;
    localparam int LATENCY = 3;
    localparam int CNT_W   = 4;
    localparam int NVEC    = 7;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    ifu_icache_burst_if #(.INSTR_W(INSTR_W), .LANES(LANES), .CNT_W(CNT_W)) bus ();

    ifu_icache_burst #(
        .INSTR_W (INSTR_W),
        .LANES   (LANES),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        string            name;
        logic [31:0]      addr;
        logic [CNT_W-1:0] count;
        int               nbeats;
        logic [127:0]     d0;
        logic [3:0]       m0;
        logic [127:0]     d1;
        logic [3:0]       m1;
    } vec_t;

    vec_t         vecs [NVEC];
    logic [127:0] exp_d;
    logic [3:0]   exp_m;
    int           seen;

    function automatic vec_t mk(input string name, input logic [31:0] addr,
                                input logic [CNT_W-1:0] count, input int nbeats,
                                input logic [127:0] d0, input logic [3:0] m0,
                                input logic [127:0] d1, input logic [3:0] m1);
        vec_t v;
        v.name = name; v.addr = addr; v.count = count; v.nbeats = nbeats;
        v.d0 = d0; v.m0 = m0; v.d1 = d1; v.m1 = m1;
        return v;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_beat(input string name, input logic [127:0] d, input logic [3:0] m,
                              input logic last);
        check({name, " valid"}, 128'(bus.rsp_valid), 128'(1));
        check({name, " data"},  bus.rsp_data, d);
        check({name, " mask"},  128'(bus.rsp_mask), 128'(m));
        check({name, " last"},  128'(bus.rsp_last), 128'(last));
`ifdef ICACHE_MISALIGN_ERR_EN
        check({name, " err"},   128'(bus.rsp_err), 128'(0));
`endif
    endtask

    task automatic check_idle(input string name);
        check({name, " idle valid"}, 128'(bus.rsp_valid), 128'(0));
        check({name, " idle ready"}, 128'(bus.req_ready), 128'(1));
        check({name, " idle busy"},  128'(bus.busy),      128'(0));
    endtask

    // Present one request at a negedge; returns just after the accepting edge.
    task automatic send_req(input logic [31:0] addr, input logic [CNT_W-1:0] cnt);
        @(negedge clk);
        check("req_ready before request", 128'(bus.req_ready), 128'(1));
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_count = cnt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    // Counts clock edges after acceptance until rsp_valid; bounded.
    task automatic wait_valid(input string name, input int exp_lat);
        int cyc;
        cyc = 0;
        @(negedge clk);
        while (!bus.rsp_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check({name, " latency"}, 128'(cyc), 128'(exp_lat));
    endtask

    task automatic run_vec(input vec_t v);
        send_req(v.addr, v.count);
        wait_valid(v.name, LATENCY);
        check_beat({v.name, " b0"}, v.d0, v.m0, v.nbeats == 1);
        if (v.nbeats == 2) begin
            @(negedge clk);
            check_beat({v.name, " b1"}, v.d1, v.m1, 1'b1);
        end
        @(negedge clk);
        check_idle(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = mk("a10_c4",  32'h10,        4'd4, 1,
                     {32'h1C, 32'h18, 32'h14, 32'h10}, 4'b1111, '0, 4'b0000);
        vecs[1] = mk("a00_c6",  32'h0,         4'd6, 2,
                     {32'hC, 32'h8, 32'h4, 32'h0}, 4'b1111,
                     {32'h0, 32'h0, 32'h14, 32'h10}, 4'b0011);
        vecs[2] = mk("wrap_c4", 32'h1F8,       4'd4, 1,
                     {32'h004, 32'h000, 32'h1FC, 32'h1F8}, 4'b1111, '0, 4'b0000);
        vecs[3] = mk("wrap_c0", 32'h1F8,       4'd0, 1,
                     {32'h004, 32'h000, 32'h1FC, 32'h1F8}, 4'b1111, '0, 4'b0000);
        vecs[4] = mk("a40_c1",  32'h40,        4'd1, 1,
                     {32'h0, 32'h0, 32'h0, 32'h40}, 4'b0001, '0, 4'b0000);
        vecs[5] = mk("xwrap_c7", 32'h1F0,      4'd7, 2,
                     {32'h1FC, 32'h1F8, 32'h1F4, 32'h1F0}, 4'b1111,
                     {32'h0, 32'h8, 32'h4, 32'h0}, 4'b0111);
        vecs[6] = mk("hi_c2",   32'h1000_0020, 4'd2, 1,
                     {32'h0, 32'h0, 32'h24, 32'h20}, 4'b0011, '0, 4'b0000);

        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_count = '0;
        bus.rsp_ready = 1'b1;
        reset_n       = 1'b1;

        // Reset asserted between clock edges takes effect immediately.
        #2 reset_n = 1'b0;
        #1;
        check("reset req_ready", 128'(bus.req_ready), 128'(1));
        check("reset rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("reset rsp_data",  bus.rsp_data, 128'(0));
        check("reset rsp_mask",  128'(bus.rsp_mask), 128'(0));
        check("reset rsp_last",  128'(bus.rsp_last), 128'(0));
        check("reset busy",      128'(bus.busy), 128'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_idle("post reset");

        for (int v = 0; v < NVEC; v++) begin
            run_vec(vecs[v]);
        end

        // Backpressure on beat 0 of an 8-instruction burst; stray request while busy.
        bus.rsp_ready = 1'b0;
        send_req(32'h0, 4'd8);
        wait_valid("bp", LATENCY);
        check_beat("bp b0", {32'hC, 32'h8, 32'h4, 32'h0}, 4'b1111, 1'b0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            if (s == 1) begin
                check("bp req_ready busy", 128'(bus.req_ready), 128'(0));
                check("bp busy",           128'(bus.busy),      128'(1));
                bus.req_valid = 1'b1;
                bus.req_addr  = 32'h100;
                bus.req_count = 4'd4;
            end
            if (s == 2) bus.req_valid = 1'b0;
            check_beat("bp b0 held", {32'hC, 32'h8, 32'h4, 32'h0}, 4'b1111, 1'b0);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check_beat("bp b1", {32'h1C, 32'h18, 32'h14, 32'h10}, 4'b1111, 1'b1);
        @(negedge clk);
        check_idle("bp");
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("bp stray request ignored", 128'(seen), 128'(0));

        // Maximum request length: 15 instructions over 4 beats, crossing the wrap.
        send_req(32'h1E0, 4'd15);
        wait_valid("max", LATENCY);
        for (int b = 0; b < 4; b++) begin
            if (b > 0) @(negedge clk);
            exp_d = '0;
            exp_m = '0;
            for (int i = 0; i < 4; i++) begin
                if (4 * b + i < 15) begin
                    exp_m[i]           = 1'b1;
                    exp_d[i*32 +: 32]  = 32'(((120 + 4 * b + i) % 128) * 4);
                end
            end
            check_beat($sformatf("max b%0d", b), exp_d, exp_m, b == 3);
        end
        @(negedge clk);
        check_idle("max");

        // Reset pulsed during beat 0 aborts the burst.
        bus.rsp_ready = 1'b0;
        send_req(32'h20, 4'd8);
        wait_valid("rst", LATENCY);
        check_beat("rst b0", {32'h2C, 32'h28, 32'h24, 32'h20}, 4'b1111, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst mid rsp_valid", 128'(bus.rsp_valid), 128'(0));
        check("rst mid rsp_data",  bus.rsp_data, 128'(0));
        check("rst mid req_ready", 128'(bus.req_ready), 128'(1));
        check("rst mid busy",      128'(bus.busy), 128'(0));
        @(negedge clk);
        reset_n       = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check("rst no beat 2", 128'(seen), 128'(0));
        run_vec(vecs[0]);

`ifdef ICACHE_MISALIGN_ERR_EN
        // Misaligned PC: immediate single error beat.
        send_req(32'h12, 4'd4);
        wait_valid("misalign", 0);
        check("misalign valid", 128'(bus.rsp_valid), 128'(1));
        check("misalign err",   128'(bus.rsp_err),   128'(1));
        check("misalign mask",  128'(bus.rsp_mask),  128'(0));
        check("misalign data",  bus.rsp_data,        128'(0));
        check("misalign last",  128'(bus.rsp_last),  128'(1));
        @(negedge clk);
        check_idle("misalign");
        check("misalign err cleared", 128'(bus.rsp_err), 128'(0));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
